cnt_bcd_display: RTL and testbench

//  Downstream consumer of the 10-bit signed counter value.
//  - Periodically samples cnt_in and converts it to sign + 3 BCD digits with a

---
 rtl/cnt_bcd_display.sv | 158 +++++++++++++++
 tb/tb_cnt_bcd_display.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/cnt_bcd_display.sv
// Samples a signed 10-bit count, converts it to sign + 3 BCD digits one bit per clock,
// and drives a time-multiplexed, active-low 4-digit 7-segment display.
module cnt_bcd_display #(
   parameter int unsigned SAMPLE_DIV = 5_000_000,
   parameter int unsigned SCAN_DIV   = 50_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] cnt_in,
   output logic       busy,
   output logic       done,
   output logic       sign,
   output logic [3:0] bcd2,
   output logic [3:0] bcd1,
   output logic [3:0] bcd0,
   output logic [3:0] an,
   output logic [6:0] seg
);

   localparam int unsigned SW  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int unsigned SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
   localparam logic [6:0] GLYPH_MINUS = 7'b0111111;

   typedef enum logic {StIdle, StConv} state_t;

   state_t          state_q;
   logic [SW-1:0]   sample_cnt_q;
   logic [SCW-1:0]  scan_cnt_q;
   logic [1:0]      idx_q;
   logic [3:0]      step_q;
   logic            sgn_q;
   logic [21:0]     shreg_q;   // {bcd scratch[11:0], magnitude[9:0]}
   logic            tick;
   logic            scan_wrap;
   logic [9:0]      mag_in;
   logic [21:0]     shreg_nxt;
   logic [3:0]      an_d;
   logic [6:0]      seg_d;

   function automatic logic [6:0] glyph(input logic [3:0] d);
      logic [6:0] g;
      case (d)
         4'd0:    g = 7'b1000000;
         4'd1:    g = 7'b1111001;
         4'd2:    g = 7'b0100100;
         4'd3:    g = 7'b0110000;
         4'd4:    g = 7'b0011001;
         4'd5:    g = 7'b0010010;
         4'd6:    g = 7'b0000010;
         4'd7:    g = 7'b1111000;
         4'd8:    g = 7'b0000000;
         4'd9:    g = 7'b0010000;
         default: g = GLYPH_BLANK;
      endcase
      return g;
   endfunction

   // One double-dabble step: correct each nibble >= 5, then shift left.
   function automatic logic [21:0] dd_step(input logic [21:0] v);
      logic [21:0] r;
      r = v;
      for (int i = 0; i < 3; i++) begin
         if (r[10+4*i +: 4] >= 4'd5) r[10+4*i +: 4] = r[10+4*i +: 4] + 4'd3;
      end
      return {r[20:0], 1'b0};
   endfunction

   always_comb begin
      tick      = (sample_cnt_q == SW'(SAMPLE_DIV - 1));
      scan_wrap = (scan_cnt_q == SCW'(SCAN_DIV - 1));
      mag_in    = cnt_in[9] ? (~cnt_in + 10'd1) : cnt_in;
      shreg_nxt = dd_step(shreg_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         sample_cnt_q <= '0;
         step_q       <= '0;
         sgn_q        <= 1'b0;
         shreg_q      <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         sign         <= 1'b0;
         bcd2         <= '0;
         bcd1         <= '0;
         bcd0         <= '0;
      end else begin
         sample_cnt_q <= tick ? '0 : sample_cnt_q + 1'b1;
         done         <= 1'b0;
         case (state_q)
            StIdle: begin
               if (tick) begin
                  sgn_q   <= cnt_in[9];
                  shreg_q <= {12'd0, mag_in};
                  step_q  <= '0;
                  busy    <= 1'b1;
                  state_q <= StConv;
               end
            end
            StConv: begin
               shreg_q <= shreg_nxt;
               step_q  <= step_q + 4'd1;
               if (step_q == 4'd9) begin
                  sign    <= sgn_q;
                  bcd2    <= shreg_nxt[21:18];
                  bcd1    <= shreg_nxt[17:14];
                  bcd0    <= shreg_nxt[13:10];
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Leading-zero blanking: tens blank only when hundreds is also zero.
   always_comb begin
      an_d  = 4'b1111;
      seg_d = GLYPH_BLANK;
      case (idx_q)
         2'd0: begin
            an_d  = 4'b1110;
            seg_d = glyph(bcd0);
         end
         2'd1: begin
            an_d  = 4'b1101;
            seg_d = (bcd2 == 4'd0 && bcd1 == 4'd0) ? GLYPH_BLANK : glyph(bcd1);
         end
         2'd2: begin
            an_d  = 4'b1011;
            seg_d = (bcd2 == 4'd0) ? GLYPH_BLANK : glyph(bcd2);
         end
         default: begin
            an_d  = 4'b0111;
            seg_d = sign ? GLYPH_MINUS : GLYPH_BLANK;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt_q <= '0;
         idx_q      <= '0;
         an         <= 4'b1111;
         seg        <= GLYPH_BLANK;
      end else begin
         scan_cnt_q <= scan_wrap ? '0 : scan_cnt_q + 1'b1;
         if (scan_wrap) idx_q <= idx_q + 2'd1;
         an  <= an_d;
         seg <= seg_d;
      end
   end

endmodule

// File: tb/tb_cnt_bcd_display.sv
// Directed bench for cnt_bcd_display: vector table of conversions and display glyphs,
// plus hand sequences for mid-conversion input change, reset abort and steady-state timing.
module tb_cnt_bcd_display;

   logic       clk;
   logic       rst;
   logic [9:0] cnt_in;
   logic       busy, done, sign;
   logic [3:0] bcd2, bcd1, bcd0, an;
   logic [6:0] seg;

   int total = 0;
   int bad   = 0;
   int bcnt  = 0;

   cnt_bcd_display #(.SAMPLE_DIV(16), .SCAN_DIV(2)) dut (
      .clk(clk), .rst(rst), .cnt_in(cnt_in), .busy(busy), .done(done), .sign(sign),
      .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0), .an(an), .seg(seg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         val;
      logic       s;
      logic [3:0] d2, d1, d0;
      logic [6:0] g0, g1, g2, g3;
   } vec_t;

   vec_t tv[9];

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   // Every wait goes through here so busy cycles of the current conversion are counted.
   task automatic tick();
      @(negedge clk);
      if (busy) bcnt++;
   endtask

   task automatic wait_done(input string nm);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!done && n < 40);
      chk({nm, "_done_seen"}, int'(done), 1);
      chk({nm, "_busy_len"}, bcnt, 10);
      bcnt = 0;
   endtask

   task automatic wait_bcnt(input int target);
      int n;
      n = 0;
      while (bcnt < target && n < 40) begin
         tick();
         n++;
      end
      chk("busy_progress", bcnt, target);
   endtask

   task automatic chk_res(input string nm, input logic s, input logic [3:0] d2,
                          input logic [3:0] d1, input logic [3:0] d0);
      chk({nm, "_sign"}, int'(sign), int'(s));
      chk({nm, "_bcd2"}, int'(bcd2), int'(d2));
      chk({nm, "_bcd1"}, int'(bcd1), int'(d1));
      chk({nm, "_bcd0"}, int'(bcd0), int'(d0));
   endtask

   initial begin
      int g[4];
      int n, prev_done, run;
      logic [3:0] prev_an;
      logic saw_done;

      tv[0] = '{-50,  1'b1, 4'd0, 4'd5, 4'd0, 7'b1000000, 7'b0010010, 7'b1111111, 7'b0111111};
      tv[1] = '{511,  1'b0, 4'd5, 4'd1, 4'd1, 7'b1111001, 7'b1111001, 7'b0010010, 7'b1111111};
      tv[2] = '{-512, 1'b1, 4'd5, 4'd1, 4'd2, 7'b0100100, 7'b1111001, 7'b0010010, 7'b0111111};
      tv[3] = '{0,    1'b0, 4'd0, 4'd0, 4'd0, 7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111};
      tv[4] = '{7,    1'b0, 4'd0, 4'd0, 4'd7, 7'b1111000, 7'b1111111, 7'b1111111, 7'b1111111};
      tv[5] = '{-9,   1'b1, 4'd0, 4'd0, 4'd9, 7'b0010000, 7'b1111111, 7'b1111111, 7'b0111111};
      tv[6] = '{100,  1'b0, 4'd1, 4'd0, 4'd0, 7'b1000000, 7'b1000000, 7'b1111001, 7'b1111111};
      tv[7] = '{38,   1'b0, 4'd0, 4'd3, 4'd8, 7'b0000000, 7'b0110000, 7'b1111111, 7'b1111111};
      tv[8] = '{-467, 1'b1, 4'd4, 4'd6, 4'd7, 7'b1111000, 7'b0000010, 7'b0011001, 7'b0111111};

      rst    = 1'b1;
      cnt_in = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_sign", int'(sign), 0);
      chk("rst_bcd", int'({bcd2, bcd1, bcd0}), 0);
      chk("rst_an", int'(an), 4'b1111);
      chk("rst_seg", int'(seg), 7'b1111111);

      cnt_in = 10'(tv[0].val);
      rst    = 1'b0;
      for (int i = 0; i < 9; i++) begin
         wait_done($sformatf("v%0d", i));
         chk_res($sformatf("v%0d", i), tv[i].s, tv[i].d2, tv[i].d1, tv[i].d0);
         cnt_in = (i < 8) ? 10'(tv[i+1].val) : 10'(230);
         for (int k = 0; k < 4; k++) g[k] = -1;
         for (int c = 0; c < 8; c++) begin
            tick();
            chk($sformatf("v%0d_one_an", i), $countones(~an), 1);
            case (an)
               4'b1110: g[0] = int'(seg);
               4'b1101: g[1] = int'(seg);
               4'b1011: g[2] = int'(seg);
               4'b0111: g[3] = int'(seg);
               default: ;
            endcase
         end
         chk($sformatf("v%0d_seg_an0", i), g[0], int'(tv[i].g0));
         chk($sformatf("v%0d_seg_an1", i), g[1], int'(tv[i].g1));
         chk($sformatf("v%0d_seg_an2", i), g[2], int'(tv[i].g2));
         chk($sformatf("v%0d_seg_an3", i), g[3], int'(tv[i].g3));
      end

      // 230 captured at E0; the change to -221 lands at E3 and must be ignored.
      wait_bcnt(3);
      cnt_in = 10'(-221);
      wait_done("chg");
      chk_res("chg", 1'b0, 4'd2, 4'd3, 4'd0);
      wait_done("nxt");
      chk_res("nxt", 1'b1, 4'd2, 4'd2, 4'd1);

      // Reset taking effect at E5 aborts the conversion.
      wait_bcnt(5);
      rst = 1'b1;
      tick();
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_sign", int'(sign), 0);
      chk("abort_bcd", int'({bcd2, bcd1, bcd0}), 0);
      rst      = 1'b0;
      bcnt     = 0;
      n        = 0;
      saw_done = 1'b0;
      do begin
         tick();
         n++;
         if (done) saw_done = 1'b1;
      end while (!busy && n < 40);
      chk("restart_clocks", n, 16);
      chk("abort_no_done", int'(saw_done), 0);
      wait_done("post_rst");
      chk_res("post_rst", 1'b1, 4'd2, 4'd2, 4'd1);

      // Steady state: done period and scan order/hold time.
      prev_done = -1;
      prev_an   = an;
      run       = -1;
      for (int c = 0; c < 64; c++) begin
         tick();
         if (done) begin
            if (prev_done >= 0) chk("done_period", c - prev_done, 16);
            prev_done = c;
            bcnt = 0;
         end
         chk("scan_one_an", $countones(~an), 1);
         if (an != prev_an) begin
            chk("scan_order", int'(an), int'({prev_an[2:0], prev_an[3]}));
            if (run >= 0) chk("scan_hold", run, 2);
            run = 1;
            prev_an = an;
         end else if (run >= 0) begin
            run++;
         end
      end
      chk("done_seen_in_window", int'(prev_done >= 0), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
